decoder_3to8_strobe: RTL and testbench

DECODER_3TO8_STROBE -- requirements
Module: decoder_3to8_strobe

---
 rtl/decoder_3to8_strobe_pkg.sv | 13 +
 rtl/dec3to8_core.sv | 14 +
 rtl/decoder_3to8_strobe.sv | 116 +++++++++++
 tb/tb_decoder_3to8_strobe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_3to8_strobe_pkg.sv
// Shared types and constants for the strobed 3-to-8 decoder.
// Holds the FSM state encoding, the default dwell length and the dwell counter width.
package decoder_3to8_strobe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DWELL_DEFAULT = 4;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/dec3to8_core.sv
// Pure combinational 3-to-8 one-hot mapping; bit N is high when code equals N.
module dec3to8_core (
    input  logic [2:0] code,
    output logic [7:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign onehot[gi] = (code == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_3to8_strobe.sv
// Registered 3-to-8 decoder that holds each accepted one-hot code for DWELL cycles,
// with a ready/valid input handshake and a done pulse on the final dwell cycle.
module decoder_3to8_strobe
    import decoder_3to8_strobe_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    output logic in_ready,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7,
    output logic out_valid,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       y_reg, y_next;
    logic             out_valid_reg, out_valid_next;
    logic             done_reg, done_next;

    logic [2:0]       code;
    logic [7:0]       onehot;
    logic             last_cycle;
    logic             accept;

    assign code = {a2, a1, a0};

    dec3to8_core u_core (
        .code   (code),
        .onehot (onehot)
    );

    // Ready depends only on state and counter so upstream may wait on it combinationally.
    assign last_cycle = (state_reg == HOLD) && (cnt_reg == LAST_CNT);
    assign in_ready   = (state_reg == IDLE) || last_cycle;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    y_next     = onehot;
                end
            end
            HOLD: begin
                if (last_cycle) begin
                    if (accept) begin
                        cnt_next = '0;
                        y_next   = onehot;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        y_next     = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                y_next     = '0;
            end
        endcase
        // done and out_valid are registered alongside y so all outputs change on the same edge.
        out_valid_next = (state_next == HOLD);
        done_next      = (state_next == HOLD) && (cnt_next == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            y_reg         <= y_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    assign y0        = y_reg[0];
    assign y1        = y_reg[1];
    assign y2        = y_reg[2];
    assign y3        = y_reg[3];
    assign y4        = y_reg[4];
    assign y5        = y_reg[5];
    assign y6        = y_reg[6];
    assign y7        = y_reg[7];
    assign out_valid = out_valid_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Bench for decoder_3to8_strobe: DWELL=4 and DWELL=1 instances, per-cycle scoreboard of
// expected {y, out_valid, done, in_ready} filled when codes are driven.
module tb_decoder_3to8_strobe;

    typedef struct packed {
        logic [7:0] y;
        logic       done;
        logic       rdy;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       in_valid4, in_valid1;
    logic [2:0] code4, code1;
    logic       rdy4, rdy1, ov4, ov1, done4, done1;
    logic [7:0] y4, y1;

    exp_t q4[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    wire logic [10:0] obs4 = {y4, ov4, done4, rdy4};
    wire logic [10:0] obs1 = {y1, ov1, done1, rdy1};

    decoder_3to8_strobe #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
        .a0(code4[0]), .a1(code4[1]), .a2(code4[2]),
        .in_ready(rdy4),
        .y0(y4[0]), .y1(y4[1]), .y2(y4[2]), .y3(y4[3]),
        .y4(y4[4]), .y5(y4[5]), .y6(y4[6]), .y7(y4[7]),
        .out_valid(ov4), .done(done4)
    );

    decoder_3to8_strobe #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
        .a0(code1[0]), .a1(code1[1]), .a2(code1[2]),
        .in_ready(rdy1),
        .y0(y1[0]), .y1(y1[1]), .y2(y1[2]), .y3(y1[3]),
        .y4(y1[4]), .y5(y1[5]), .y6(y1[6]), .y7(y1[7]),
        .out_valid(ov1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t idle_e();
        exp_t e;
        e.y    = '0;
        e.done = 1'b0;
        e.rdy  = 1'b1;
        return e;
    endfunction

    function automatic logic [10:0] expv(exp_t e);
        return {e.y, |e.y, e.done, e.rdy};
    endfunction

    function automatic exp_t pop4();
        if (q4.size() > 0) return q4.pop_front();
        return idle_e();
    endfunction

    function automatic exp_t pop1();
        if (q1.size() > 0) return q1.pop_front();
        return idle_e();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // An accept happens when the bench drives valid in a cycle it expects the DUT to be ready.
    task automatic drive4(input logic v, input logic [2:0] c, input logic rdy);
        exp_t e;
        in_valid4 = v;
        code4     = c;
        if (v && rdy) begin
            for (int k = 0; k < 4; k++) begin
                e.y    = 8'b1 << c;
                e.done = (k == 3);
                e.rdy  = (k == 3);
                q4.push_back(e);
            end
        end
    endtask

    task automatic drive1(input logic v, input logic [2:0] c, input logic rdy);
        exp_t e;
        in_valid1 = v;
        code1     = c;
        if (v && rdy) begin
            e.y    = 8'b1 << c;
            e.done = 1'b1;
            e.rdy  = 1'b1;
            q1.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (obs4 !== expv(idle_e())) begin
            errors++;
            $display("FAIL reset_dwell4 got=%b exp=%b", obs4, expv(idle_e()));
        end
        checks++;
        if (obs1 !== expv(idle_e())) begin
            errors++;
            $display("FAIL reset_dwell1 got=%b exp=%b", obs1, expv(idle_e()));
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs4 !== expv(idle_e())) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs4, expv(idle_e()));
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            tick();
            e = pop4();
            checks++;
            if (obs4 !== expv(e)) begin
                errors++;
                $display("FAIL single_code5 cyc=%0d got=%b exp=%b", i, obs4, expv(e));
            end
            drive4(i == 0, 3'd5, e.rdy);
        end
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            tick();
            e = pop4();
            checks++;
            if (obs4 !== expv(e)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs4, expv(e));
            end
            drive4(i <= 4, (i == 0) ? 3'd3 : 3'd6, e.rdy);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_ignore();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            tick();
            e = pop4();
            checks++;
            if (obs4 !== expv(e)) begin
                errors++;
                $display("FAIL ignore_midhold cyc=%0d got=%b exp=%b", i, obs4, expv(e));
            end
            drive4((i == 0) || (i == 2) || (i == 3), (i == 0) ? 3'd2 : 3'd7, e.rdy);
        end
        $display("test_ignore done");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = pop4();
            checks++;
            if (obs4 !== expv(e)) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got=%b exp=%b", i, obs4, expv(e));
            end
            drive4(i == 0, 3'd4, e.rdy);
            if (i == 2) rst_n = 1'b0;
        end
        tick();
        q4.delete();
        checks++;
        if (obs4 !== expv(idle_e())) begin
            errors++;
            $display("FAIL reset_mid_abort got=%b exp=%b", obs4, expv(idle_e()));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs4 !== expv(idle_e())) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, obs4, expv(idle_e()));
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_dwell1();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = pop1();
            checks++;
            if (obs1 !== expv(e)) begin
                errors++;
                $display("FAIL dwell1_stream cyc=%0d got=%b exp=%b", i, obs1, expv(e));
            end
            drive1(i < 8, i[2:0], e.rdy);
        end
        $display("test_dwell1 done");
    endtask

    task automatic test_sweep();
        exp_t e;
        int   sent = 0;
        int   cyc  = 0;
        while (cyc < 400 && !(sent == 8 && q4.size() == 0)) begin
            tick();
            e = pop4();
            checks++;
            if (obs4 !== expv(e)) begin
                errors++;
                $display("FAIL sweep cyc=%0d got=%b exp=%b", cyc, obs4, expv(e));
            end
            checks++;
            if ($countones(y4) > 1 || ov4 !== (|y4)) begin
                errors++;
                $display("FAIL sweep_onehot cyc=%0d y=%b out_valid=%b", cyc, y4, ov4);
            end
            if (e.rdy) begin
                if (sent < 8 && $urandom_range(0, 2) == 0) begin
                    drive4(1'b1, sent[2:0], 1'b1);
                    sent++;
                end else begin
                    drive4(1'b0, 3'd0, 1'b1);
                end
            end else begin
                drive4(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
            end
            cyc++;
        end
        drive4(1'b0, 3'd0, 1'b0);
        checks++;
        if (sent != 8 || q4.size() != 0) begin
            errors++;
            $display("FAIL sweep_timeout sent=%0d pending=%0d", sent, q4.size());
        end
        $display("test_sweep done cycles=%0d", cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        code4     = 3'd0;
        code1     = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_dwell1();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
